line_buffer_scheduler: RTL
==========================

# line_buffer_scheduler

Sequencing controller for the 3x3 neighbourhood filter's line-buffer bank. It steers incoming pixels into a ring of NUM_BUFS line buffers and decides when three complete lines are available. It then drives a one-pixel-per-cycle read pass across those three lines and raises a one-cycle interrupt as each line buffer is freed. The interrupt is the host's cue to send the next image line. It sits between the slave pixel interface and the line buffers / convolution window inside the image-processing top level.

## Interface

- LINE_WIDTH, 512, pixels per image line.
- NUM_BUFS, 4, line buffers in the ring (fixed window height 3, so NUM_BUFS >= 4).
- CNT_W, $clog2(NUM_BUFS*LINE_WIDTH+1), width of the occupancy counter.

- axi_clk  in  1  single clock, all state on rising edge.
- axi_reset  in  1  asynchronous, active-high reset.
- i_pixel_valid  in  1  incoming pixel strobe, one pixel per asserted cycle.
- o_data_ready  out  1  high when occupancy < NUM_BUFS*LINE_WIDTH.
- o_wr_buf_en  out  NUM_BUFS  one-hot write enable to the line buffer currently being filled.
- i_rd_ready  in  1  downstream can accept a window this cycle.
- o_rd_buf_en  out  NUM_BUFS  read enable, three bits set during a read pass.
- o_rd_sel  out  $clog2(NUM_BUFS)  index of the top-row buffer, the window mux select.
- o_window_valid  out  1  window data valid, aligned to the one-cycle buffer read latency.
- o_intr  out  1  one-cycle pulse when a line read pass completes.
- o_fill_count  out  CNT_W  pixels written and not yet retired.

## Operation

- **Write side.** The accept condition is `wr_acc = i_pixel_valid & o_data_ready`.
  - `o_wr_buf_en = wr_acc ? onehot(wr_ptr) : 0` (combinational).
  - `wr_col` counts accepted pixels 0..LINE_WIDTH-1.
  - On `wr_col == LINE_WIDTH-1` with `wr_acc`, `wr_col` wraps to 0 and `wr_ptr` increments mod NUM_BUFS.
  - Pixels presented while `o_data_ready == 0` are dropped: no enable, no counter change.
- **Read-side FSM.** States are IDLE and READ.
  - IDLE -> READ when registered `o_fill_count >= 3*LINE_WIDTH`.
  - In READ, `rd_adv = i_rd_ready`.
  - `o_rd_buf_en = rd_adv ? onehot(rd_sel) | onehot(rd_sel+1) | onehot(rd_sel+2) : 0`, with all indices mod NUM_BUFS.
  - `rd_col` counts advances 0..LINE_WIDTH-1.
  - On `rd_col == LINE_WIDTH-1` with `rd_adv`: go to IDLE, `rd_col` <= 0, `rd_sel` <= `rd_sel+1` mod NUM_BUFS, and `o_intr` <= 1 for exactly one cycle.
  - There is always at least one IDLE cycle between read passes.
- **Occupancy.** `o_fill_count` goes +1 on `wr_acc` and -1 on `rd_adv`.
  - If both occur in the same cycle, the count is unchanged.
  - The count never exceeds NUM_BUFS*LINE_WIDTH and never goes below 0. This follows by construction: reads only happen when count >= 3*LINE_WIDTH.
- **Window valid.** `o_window_valid` is `rd_adv` registered one cycle.
- **Wrap-around.** Example: `rd_sel` = 3 with NUM_BUFS = 4 gives `o_rd_buf_en` = 1011. `wr_ptr` wraps from 3 to 0.
- **Reset.** Asserting `axi_reset` at any time, including mid-READ, immediately clears all state.
  - Clears: FSM (to IDLE), `wr_ptr`, `wr_col`, `rd_sel`, `rd_col`, and `o_fill_count`.
  - Drives `o_intr` and `o_window_valid` to 0.
  - No partial line survives reset.

## Timing

- Reset values:
  - `o_wr_buf_en` 0, `o_rd_buf_en` 0, `o_rd_sel` 0, `o_window_valid` 0, `o_intr` 0, `o_fill_count` 0.
  - `o_data_ready` 1, since it derives from the count.
- Combinational outputs: `o_wr_buf_en`, `o_rd_buf_en`, `o_data_ready`. `o_rd_sel` is a register output.
- Registered outputs: `o_window_valid` and `o_intr`.
- Latency from the accept that brings the count to 3*LINE_WIDTH:
  - Count register updates at edge N.
  - FSM enters READ at edge N+1.
  - First `o_rd_buf_en` appears in cycle N+1, first `o_window_valid` in cycle N+2.
- `o_intr` rises the cycle after the last read advance. It coincides with the last `o_window_valid` and with the updated `o_rd_sel`.
- A read pass with `i_rd_ready` held high lasts exactly LINE_WIDTH cycles.

## Test plan

- **Reset.** Hold `axi_reset` 5 cycles with random `i_pixel_valid` -> all outputs at their reset values and `o_wr_buf_en` 0 throughout.
- **Prime and first line.** Stream 1536 pixels back-to-back with `i_rd_ready`=1.
  - `o_wr_buf_en` is 0001, then 0010, then 0100, 512 cycles each.
  - READ starts one cycle after the count reaches 1536; `o_rd_buf_en` = 0111 for 512 cycles.
  - `o_window_valid` is 512 cycles long, lagging by one.
  - One `o_intr` pulse; `o_rd_sel` becomes 1 and `o_fill_count` becomes 1024.
- **Full.** Write 2048 pixels with `i_rd_ready`=0.
  - `o_data_ready` drops at count 2048.
  - An extra 10 valid pixels produce no `o_wr_buf_en`; count stays 2048.
  - `wr_ptr` has wrapped to 0.
- **Simultaneous write/read.** During READ, write continuously -> `o_fill_count` is constant. Wrap case: `rd_sel`=3 gives `o_rd_buf_en` = 1011.
- **Stall.** Drop `i_rd_ready` for 7 cycles mid-line.
  - `o_rd_buf_en` is 0 and `rd_col` holds.
  - `o_window_valid` is low for 7 cycles.
  - The pass ends 7 cycles later, with `o_intr` still one cycle wide.
- **Reset mid-READ.** Assert `axi_reset` at `rd_col`=200 -> immediate return to reset values, no `o_intr`, and a clean restart on the next prime.

Source files
------------

// File: rtl/line_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_scheduler
// Purpose  : Steers incoming pixels around a ring of line buffers, tracks
//            occupancy, and runs three-line read passes for the 3x3 window,
//            pulsing an interrupt as each line buffer is retired.
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer_scheduler #(
  parameter int LINE_WIDTH = 512,
  parameter int NUM_BUFS   = 4,
  parameter int CNT_W      = $clog2(NUM_BUFS*LINE_WIDTH+1)
) (
  input  logic                        axi_clk,
  input  logic                        axi_reset,
  input  logic                        i_pixel_valid,
  output logic                        o_data_ready,
  output logic [NUM_BUFS-1:0]         o_wr_buf_en,
  input  logic                        i_rd_ready,
  output logic [NUM_BUFS-1:0]         o_rd_buf_en,
  output logic [$clog2(NUM_BUFS)-1:0] o_rd_sel,
  output logic                        o_window_valid,
  output logic                        o_intr,
  output logic [CNT_W-1:0]            o_fill_count
);

  localparam int SEL_W = $clog2(NUM_BUFS);
  localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(NUM_BUFS*LINE_WIDTH);
  localparam logic [CNT_W-1:0] THREE_LINES = CNT_W'(3*LINE_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL    = COL_W'(LINE_WIDTH-1);
  localparam logic [SEL_W-1:0] LAST_BUF    = SEL_W'(NUM_BUFS-1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [SEL_W-1:0] rd_sel_q, rd_sel_d;
  logic [COL_W-1:0] rd_col_q, rd_col_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             wv_q, wv_d;
  logic             intr_q, intr_d;

  logic wr_acc;
  logic rd_adv;
  logic rd_last;

  // Ring index arithmetic that also works for non-power-of-two ring sizes
  function automatic logic [SEL_W-1:0] ring_add(input logic [SEL_W-1:0] base,
                                                input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_BUFS) s = s - NUM_BUFS;
    return SEL_W'(s);
  endfunction

  // Accept/advance strobes; writes are held off while reset is asserted
  always_comb begin
    o_data_ready = (fill_q < FULL_CNT);
    wr_acc       = i_pixel_valid & o_data_ready & ~axi_reset;
    rd_adv       = (state_q == S_READ) & i_rd_ready;
    rd_last      = rd_adv & (rd_col_q == LAST_COL);
  end

  // Write side: one-hot enable and column/pointer advance
  always_comb begin
    o_wr_buf_en = '0;
    wr_col_d    = wr_col_q;
    wr_ptr_d    = wr_ptr_q;
    if (wr_acc) begin
      o_wr_buf_en[wr_ptr_q] = 1'b1;
      if (wr_col_q == LAST_COL) begin
        wr_col_d = '0;
        wr_ptr_d = (wr_ptr_q == LAST_BUF) ? '0 : wr_ptr_q + SEL_W'(1);
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end
  end

  // Read FSM next state, three-line read enable and pass bookkeeping
  always_comb begin
    state_d     = state_q;
    rd_col_d    = rd_col_q;
    rd_sel_d    = rd_sel_q;
    o_rd_buf_en = '0;
    wv_d        = rd_adv;
    intr_d      = rd_last;
    unique case (state_q)
      S_IDLE: begin
        if (fill_q >= THREE_LINES) state_d = S_READ;
      end
      S_READ: begin
        if (rd_adv) begin
          for (int k = 0; k < 3; k++) o_rd_buf_en[ring_add(rd_sel_q, k)] = 1'b1;
          if (rd_last) begin
            state_d  = S_IDLE;
            rd_col_d = '0;
            rd_sel_d = ring_add(rd_sel_q, 1);
          end else begin
            rd_col_d = rd_col_q + COL_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy: simultaneous write and read cancel out
  always_comb begin
    fill_d = fill_q;
    unique case ({wr_acc, rd_adv})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  // State registers; reset discards any partial line immediately
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      wr_col_q <= '0;
      rd_sel_q <= '0;
      rd_col_q <= '0;
      fill_q   <= '0;
      wv_q     <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      wr_col_q <= wr_col_d;
      rd_sel_q <= rd_sel_d;
      rd_col_q <= rd_col_d;
      fill_q   <= fill_d;
      wv_q     <= wv_d;
      intr_q   <= intr_d;
    end
  end

  assign o_rd_sel       = rd_sel_q;
  assign o_window_valid = wv_q;
  assign o_intr         = intr_q;
  assign o_fill_count   = fill_q;

endmodule
`default_nettype wire
